// File: rtl/pic_pkg.sv
// Shared constants, state encoding and priority-rank helper for the
// rotating-priority interrupt controller core.
package pic_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_VEC  = 2'd1;
  localparam logic [1:0] ADDR_IMR  = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  localparam int CTRL_LTIM = 0;
  localparam int CTRL_AEOI = 1;
  localparam int CTRL_AROT = 2;

  localparam int EOI_SPEC = 7;
  localparam int EOI_ROT  = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    WAIT2 = 1'b1
  } state_t;

  // Rank 0 is the highest priority, i.e. index lp+1 (mod n).
  function automatic int prio_rank(int idx, int lp, int n);
    int r;
    r = idx - lp - 1;
    if (r < 0) r = r + n;
    return r;
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Circular priority encoder: finds the highest-priority set bit of i_vec,
// where priority starts at i_lp+1 and decreases circularly.
module pic_prio_resolver #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  input  logic [IW-1:0] i_lp,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    // Scan lowest priority first so the highest-priority hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(i_lp) + 1 + k;
      if (j >= N) j = j - N;
      if (i_vec[IW'(j)]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pic_priority_core.sv
// Parametrised interrupt-controller core: IRR/ISR/IMR, rotating priority,
// two-pulse acknowledge returning a vector built from a programmable base.
module pic_priority_core
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  parameter  int DATA_W  = 8,
  localparam int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  input  logic               inta,
  output logic               int_o,
  output logic [DATA_W-1:0]  vec,
  output logic               vec_valid
);

  localparam logic [IDX_W-1:0] LP_RST = IDX_W'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0]      r_irr, r_isr, r_imr, r_irq_prev;
  logic [DATA_W-1:IDX_W]   r_vec_base;
  logic [DATA_W-1:0]       r_rdata, r_vec;
  logic [2:0]              r_ctrl;
  logic [IDX_W-1:0]        r_lp, r_g;
  logic                    r_spur, r_int, r_vec_valid;
  state_t                  r_state, w_state_next;

  logic [NUM_IRQ-1:0] w_pend_vec, w_grant_mask, w_irr_next, w_isr_next;
  logic [IDX_W-1:0]   w_pend_idx, w_svc_idx, w_eoi_idx, w_grant, w_lp_next;
  logic               w_pend_found, w_svc_found;
  logic               w_wr_ctrl, w_ack1, w_ack2, w_eoi_act, w_int_next;
  logic [7:0]         w_eoi_cmd;
  logic [DATA_W-1:0]  w_rd_data;
  int                 w_pend_rank, w_svc_rank;

  assign w_pend_vec = r_irr & ~r_imr;

  pic_prio_resolver #(.N(NUM_IRQ)) u_pend (
    .i_vec   (w_pend_vec),
    .i_lp    (r_lp),
    .o_found (w_pend_found),
    .o_idx   (w_pend_idx)
  );

  pic_prio_resolver #(.N(NUM_IRQ)) u_svc (
    .i_vec   (r_isr),
    .i_lp    (r_lp),
    .o_found (w_svc_found),
    .o_idx   (w_svc_idx)
  );

  assign w_wr_ctrl = wr_en && (addr == ADDR_CTRL);
  assign w_ack1    = inta && (r_state == IDLE) && !w_wr_ctrl;
  assign w_ack2    = inta && (r_state == WAIT2) && !w_wr_ctrl;
  assign w_eoi_cmd = 8'(wdata);
  assign w_eoi_idx = w_eoi_cmd[EOI_SPEC] ? wdata[IDX_W-1:0] : w_svc_idx;
  assign w_eoi_act = wr_en && (addr == ADDR_EOI) && (|r_isr) &&
                     (int'(w_eoi_idx) < NUM_IRQ);

  // No pending request at ACK1 yields the spurious index NUM_IRQ-1.
  assign w_grant      = w_pend_found ? w_pend_idx : LP_RST;
  assign w_grant_mask = (w_ack1 && w_pend_found) ? (NUM_IRQ'(1) << w_pend_idx) : '0;

  assign w_irr_next = r_ctrl[CTRL_LTIM] ? (irq & ~w_grant_mask)
                                        : ((r_irr & ~w_grant_mask) | (irq & ~r_irq_prev));

  assign w_pend_rank = prio_rank(int'(w_pend_idx), int'(r_lp), NUM_IRQ);
  assign w_svc_rank  = prio_rank(int'(w_svc_idx), int'(r_lp), NUM_IRQ);
  assign w_int_next  = w_pend_found && (!w_svc_found || (w_pend_rank < w_svc_rank)) &&
                       (r_state == IDLE) && !w_ack1;

  always_comb begin
    w_isr_next = r_isr;
    w_lp_next  = r_lp;
    if (w_eoi_act) begin
      w_isr_next = w_isr_next & ~(NUM_IRQ'(1) << w_eoi_idx);
      if (w_eoi_cmd[EOI_ROT] || r_ctrl[CTRL_AROT]) w_lp_next = w_eoi_idx;
    end
    if (w_ack2 && r_ctrl[CTRL_AEOI] && !r_spur) begin
      w_isr_next = w_isr_next & ~(NUM_IRQ'(1) << r_g);
      if (r_ctrl[CTRL_AROT]) w_lp_next = r_g;
    end
    // A same-cycle ACK1 set wins over any clear above.
    w_isr_next = w_isr_next | w_grant_mask;
  end

  always_comb begin
    w_rd_data = '0;
    case (addr)
      ADDR_CTRL: w_rd_data = DATA_W'(r_irr);
      ADDR_VEC:  w_rd_data = DATA_W'(r_isr);
      ADDR_IMR:  w_rd_data = DATA_W'(r_imr);
      default:   w_rd_data = DATA_W'(r_ctrl);
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (w_wr_ctrl) begin
      w_state_next = IDLE;
    end else if (inta) begin
      case (r_state)
        IDLE:    w_state_next = WAIT2;
        WAIT2:   w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irr       <= '0;
      r_isr       <= '0;
      r_imr       <= '0;
      r_irq_prev  <= '0;
      r_vec_base  <= '0;
      r_ctrl      <= '0;
      r_lp        <= LP_RST;
      r_g         <= '0;
      r_spur      <= 1'b0;
      r_int       <= 1'b0;
      r_rdata     <= '0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
    end else begin
      r_irq_prev  <= irq;
      r_vec_valid <= 1'b0;
      if (rd_en) r_rdata <= w_rd_data;
      if (w_wr_ctrl) begin
        r_ctrl <= 3'(wdata);
        r_irr  <= '0;
        r_isr  <= '0;
        r_imr  <= '0;
        r_lp   <= LP_RST;
        r_int  <= 1'b0;
      end else begin
        r_irr <= w_irr_next;
        r_isr <= w_isr_next;
        r_lp  <= w_lp_next;
        r_int <= w_int_next;
        if (wr_en && (addr == ADDR_VEC)) r_vec_base <= wdata[DATA_W-1:IDX_W];
        if (wr_en && (addr == ADDR_IMR)) r_imr <= wdata[NUM_IRQ-1:0];
        if (w_ack1) begin
          r_g    <= w_grant;
          r_spur <= !w_pend_found;
        end
        if (w_ack2) begin
          r_vec       <= {r_vec_base, r_g};
          r_vec_valid <= 1'b1;
        end
      end
    end
  end

  assign rdata     = r_rdata;
  assign int_o     = r_int;
  assign vec       = r_vec;
  assign vec_valid = r_vec_valid;

endmodule

// File: doc/pic_priority_core.md
Name: pic_priority_core

Overview:
- Parametrised, fully synchronous interrupt-controller core, successor to the fixed 8-input control logic.
- Holds IRR, ISR and IMR for NUM_IRQ request lines and a rotating-priority resolver.
- Runs a two-pulse acknowledge state machine and returns a vector built from a programmable base.
- Sits between the CPU-side bus decoder and the raw irq pins; generalises channel count and data width, and adds per-block edge/level mode, auto-rotate and a defined spurious-ack response.

Parameters:
- NUM_IRQ, 8: number of request lines, 2..DATA_W.
- DATA_W, 8: bus data width, at least NUM_IRQ.
- IDX_W, $clog2(NUM_IRQ): index width, derived and not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  request lines, synchronous to clk.
- wr_en  in  1  one-cycle write strobe.
- rd_en  in  1  one-cycle read strobe.
- addr  in  2  register select.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  registered read data.
- inta  in  1  one-cycle strobe per CPU acknowledge pulse.
- int_o  out  1  interrupt request to CPU.
- vec  out  DATA_W  vector.
- vec_valid  out  1  one-cycle qualifier for vec.

Behaviour:
- Reset (async, rst_n=0):
  - irr, isr, imr, vec_base, ctrl = 0; lp = NUM_IRQ-1.
  - state = IDLE; int_o = 0, rdata = 0, vec = 0, vec_valid = 0.
- Writes (addr):
  - 0 = CTRL: bit0 LTIM (1 = level), bit1 AEOI, bit2 AUTO_ROT. Writing CTRL re-initialises: irr/isr/imr cleared, lp = NUM_IRQ-1, state = IDLE.
  - 1 = VEC_BASE.
  - 2 = IMR.
  - 3 = EOI: bit7 specific, bit6 rotate, bits[IDX_W-1:0] level.
- Reads: registered, 1-cycle latency. addr 0 = IRR, 1 = ISR, 2 = IMR, 3 = {ctrl, zero-padded}. rdata holds its value between reads.
- IRR capture:
  - Edge mode: bit sets on a 0->1 of irq (previous sample held in a register); clears on ACK1 of that bit; otherwise stays set even if irq drops.
  - Level mode: irr = irq each cycle, except the bit granted at ACK1 reads 0 for that cycle.
  - Masking never blocks IRR capture.
- Priority:
  - Highest priority index = (lp+1) mod NUM_IRQ, decreasing circularly.
  - pend = highest-priority bit of irr & ~imr.
  - svc = highest-priority bit set in isr.
  - int_o (registered) = 1 when pend exists and ranks strictly above svc (or isr has no bit set), and state = IDLE.
- Acknowledge FSM, states IDLE -> WAIT2 -> IDLE:
  - IDLE + inta: freeze index g = pend. If none, g = NUM_IRQ-1 is spurious and isr is not set; otherwise isr[g] <= 1 and the edge irr[g] is cleared. int_o <= 0; go to WAIT2.
  - WAIT2 + inta: next cycle vec = {vec_base[DATA_W-1:IDX_W], g} and vec_valid = 1 for one cycle.
    - If AEOI and not spurious: isr[g] <= 0; if AUTO_ROT, lp <= g.
    - Go to IDLE.
  - inta held across consecutive cycles counts as consecutive pulses.
- EOI:
  - Non-specific clears svc; specific clears isr[level].
  - With rotate (bit6) or AUTO_ROT, lp <= cleared index.
  - EOI with isr = 0 is a no-op, including on lp.
- Simultaneous events:
  - EOI and ACK1 in the same cycle: both apply; a set of the same bit wins.
  - Rising edge and ACK1 clear of the same irr bit: the set wins.
  - CTRL write overrides any inta in the same cycle.
  - Reset mid-WAIT2 aborts with no vec_valid.

Decomposition:
- Shared package pic_pkg holds: address constants ADDR_CTRL/VEC/IMR/EOI, CTRL bit positions, EOI bit positions, and the state enum {IDLE, WAIT2}.
- One sub-module, pic_prio_resolver (combinational): inputs are a vector and lp; outputs are a found flag and index. It is instantiated twice, once for pend and once for svc.

Test Plan:
- Reset, then irq=8'h60, VEC_BASE=8'h40, edge mode, two inta pulses -> int_o=1; vec=8'h45 with vec_valid for 1 cycle; isr=8'h20; irr=8'h40.
- AEOI=1 and AUTO_ROT=1, irq bit 2 asserted, full ack -> isr returns to 0, lp=2, then bit 3 is highest priority. Assert irq 8'h12 -> vec low bits = 4.
- Nesting: bit 5 in service, raise bit 2 -> int_o=1. Raise bit 6 only -> int_o stays 0. Non-specific EOI -> isr=0.
- IMR=8'hFF with irq 8'h01 -> irr=8'h01, int_o=0. IMR=0 -> int_o=1 within 1 cycle.
- Spurious: inta with no pending request -> vec low bits = NUM_IRQ-1, isr unchanged.
- NUM_IRQ=16, DATA_W=16 build: irq[12] asserted, VEC_BASE=16'h0100, full ack -> vec=16'h010C. Reset asserted during WAIT2 -> no vec_valid, all registers at reset values.
